// File: rtl/ped_signal_ctrl.sv
// ped_signal_ctrl: pedestrian signal head FSM; define PED_COUNTDOWN_EN for the FLASH countdown digit on hex_count
module ped_signal_ctrl #(
  parameter int WALK_TIME  = 8,
  parameter int FLASH_TIME = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       enable,
  input  logic       walk_req,
  input  logic       grant,
  output logic       walk_active,
  output logic       ped_done,
  output logic [6:0] hex_symbol,
  output logic [6:0] hex_count
);
  typedef enum logic [1:0] {OFF, DONT_WALK, WALK, FLASH} state_t;
  state_t     state;
  logic [7:0] cnt;
  logic       req_l;
  logic       ph;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= OFF;
      cnt      <= 8'd0;
      req_l    <= 1'b0;
      ph       <= 1'b0;
      ped_done <= 1'b0;
    end else begin
      ped_done <= 1'b0;
      if (!enable) begin
        state <= OFF;
        cnt   <= 8'd0;
        req_l <= 1'b0;
        ph    <= 1'b0;
      end else begin
        if (walk_req && state != OFF) req_l <= 1'b1;
        case (state)
          OFF:       state <= DONT_WALK;
          DONT_WALK: if (req_l && grant) begin
            state <= WALK;
            cnt   <= 8'(WALK_TIME);
            req_l <= 1'b0;
          end
          WALK:      if (tick) begin
            if (cnt == 8'd1) begin
              state <= FLASH;
              cnt   <= 8'(FLASH_TIME);
              ph    <= 1'b1;
            end else cnt <= cnt - 8'd1;
          end
          FLASH:     if (tick) begin
            cnt <= cnt - 8'd1;
            ph  <= ~ph;
            if (cnt == 8'd1) begin
              state    <= DONT_WALK;
              ped_done <= 1'b1;
            end
          end
          default:   state <= OFF;
        endcase
      end
    end
  end
  assign walk_active = state == WALK || state == FLASH;
  assign hex_symbol  = (state == DONT_WALK || (state == FLASH && ph)) ? 7'b0100001 :
                       state == WALK ? 7'b1011111 : 7'b1111111;
`ifdef PED_COUNTDOWN_EN
  logic [6:0] digit;
  always_comb begin
    digit = 7'b1111111;
    case (cnt)
      8'd0: digit = 7'b1000000;
      8'd1: digit = 7'b1111001;
      8'd2: digit = 7'b0100100;
      8'd3: digit = 7'b0110000;
      8'd4: digit = 7'b0011001;
      8'd5: digit = 7'b0010010;
      8'd6: digit = 7'b0000010;
      8'd7: digit = 7'b1111000;
      8'd8: digit = 7'b0000000;
      8'd9: digit = 7'b0010000;
      default: digit = 7'b1111111;
    endcase
  end
  assign hex_count = state == FLASH ? digit : 7'b1111111;
`else
  assign hex_count = 7'b1111111;
`endif
endmodule
